// File: rtl/or_chk_pkg.sv
// Shared types and constants for the exhaustive-sweep OR-gate response checker.
package or_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int N_VEC     = 1 << DEF_WIDTH;
  localparam int DEF_LAT   = 1;
  localparam int MAX_LAT   = 7;

endpackage

// File: rtl/chk_delay_line.sv
// LAT-deep shift register carrying {accept, vec} so each vector meets its DUT
// response; LAT=0 degenerates to a wire.
module chk_delay_line #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] vec_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] vec_o
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = clk ^ clear_i;
      assign valid_o     = valid_i;
      assign vec_o       = vec_i;
    end else begin : g_pipe
      logic [LAT-1:0]            valid_q;
      logic [LAT-1:0][WIDTH-1:0] vec_q;

      // NOTE: the payload stages are cleared along with the valid bits so a
      // fresh sweep never sees stale data, even though only valid gates use.
      always_ff @(posedge clk) begin
        if (clear_i) begin
          valid_q <= '0;
          vec_q   <= '0;
        end else begin
          valid_q[0] <= valid_i;
          vec_q[0]   <= vec_i;
          for (int i = 1; i < LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            vec_q[i]   <= vec_q[i-1];
          end
        end
      end

      assign valid_o = valid_q[LAT-1];
      assign vec_o   = vec_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/or8_response_checker.sv
// Receives an exhaustive ascending sweep of vectors plus the OR-gate DUT's
// responses, checks order and golden OR reduction, and tallies the results.
module or8_response_checker
  import or_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = DEF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] vec,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   chk_cnt,
  output logic [WIDTH:0]   err_cnt,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic             first_fail_valid,
  output logic             seq_err
);

  localparam logic [WIDTH:0] CNT_ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] CNT_FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] CNT_LAST = CNT_FULL - CNT_ONE;

  state_e           state_q;
  logic [WIDTH:0]   exp_idx_q;
  logic [WIDTH:0]   chk_cnt_q;
  logic [WIDTH:0]   err_cnt_q;
  logic [WIDTH-1:0] ff_vec_q;
  logic             ff_valid_q;
  logic             seq_err_q;

  logic             start_sweep;
  logic             accept;
  logic             dl_clear;
  logic             dly_valid;
  logic [WIDTH-1:0] dly_vec;
  logic             cmp_en;
  logic             mismatch;

  // A start pulse only opens a sweep from IDLE or DONE; inside RUN it is ignored.
  assign start_sweep = start && (state_q != ST_RUN);
  // exp_idx_q doubles as the accepted count; its MSB marks a full sweep.
  assign accept      = (state_q == ST_RUN) && vec_valid && !exp_idx_q[WIDTH];
  assign dl_clear    = rst || start_sweep;

  chk_delay_line #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_delay (
    .clk     (clk),
    .clear_i (dl_clear),
    .valid_i (accept),
    .vec_i   (vec),
    .valid_o (dly_valid),
    .vec_o   (dly_vec)
  );

  assign cmp_en   = (state_q == ST_RUN) && dly_valid;
  assign mismatch = cmp_en && ((|dly_vec) != dut_out);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values of the other registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      exp_idx_q  <= '0;
      chk_cnt_q  <= '0;
      err_cnt_q  <= '0;
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else if (start_sweep) begin
      state_q    <= ST_RUN;
      exp_idx_q  <= '0;
      chk_cnt_q  <= '0;
      err_cnt_q  <= '0;
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (accept) begin
        exp_idx_q <= exp_idx_q + CNT_ONE;
        if (vec != exp_idx_q[WIDTH-1:0]) begin
          seq_err_q <= 1'b1;
        end
      end
      if (cmp_en) begin
        chk_cnt_q <= chk_cnt_q + CNT_ONE;
        if (mismatch) begin
          err_cnt_q <= err_cnt_q + CNT_ONE;
          if (!ff_valid_q) begin
            ff_vec_q   <= dly_vec;
            ff_valid_q <= 1'b1;
          end
        end
        if (chk_cnt_q == CNT_LAST) begin
          state_q <= ST_DONE;
        end
      end
    end
  end

  assign busy             = (state_q == ST_RUN);
  assign done             = (state_q == ST_DONE);
  assign pass             = done && (err_cnt_q == '0) && !seq_err_q;
  assign chk_cnt          = chk_cnt_q;
  assign err_cnt          = err_cnt_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_valid = ff_valid_q;
  assign seq_err          = seq_err_q;

endmodule

// File: tb/tb_or8_response_checker.sv
// Directed bench: three checker builds (LAT 1/0/3) share one stimulus stream,
// each fed by its own latency-matched OR-gate model.
module tb_or8_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       vec_valid;
  logic [7:0] vec;
  logic       stuck0;

  always #5 clk = ~clk;

  // OR-gate DUT models: response to the vector presented LAT cycles earlier.
  logic [7:0] hist1 = '0, hist2 = '0, hist3 = '0;
  always @(posedge clk) begin
    hist1 <= vec;
    hist2 <= hist1;
    hist3 <= hist2;
  end

  logic dut_out0, dut_out1, dut_out3;
  assign dut_out0 = stuck0 ? 1'b0 : |vec;
  assign dut_out1 = stuck0 ? 1'b0 : |hist1;
  assign dut_out3 = stuck0 ? 1'b0 : |hist3;

  logic       busy0, done0, pass0, ffok0, seq0;
  logic       busy1, done1, pass1, ffok1, seq1;
  logic       busy3, done3, pass3, ffok3, seq3;
  logic [8:0] chk0, err0, chk1, err1, chk3, err3;
  logic [7:0] ffv0, ffv1, ffv3;

  or8_response_checker #(.WIDTH(8), .LAT(0)) u_l0 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0),
    .chk_cnt(chk0), .err_cnt(err0), .first_fail_vec(ffv0),
    .first_fail_valid(ffok0), .seq_err(seq0));

  or8_response_checker #(.WIDTH(8), .LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
    .chk_cnt(chk1), .err_cnt(err1), .first_fail_vec(ffv1),
    .first_fail_valid(ffok1), .seq_err(seq1));

  or8_response_checker #(.WIDTH(8), .LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_out(dut_out3), .busy(busy3), .done(done3), .pass(pass3),
    .chk_cnt(chk3), .err_cnt(err3), .first_fail_vec(ffv3),
    .first_fail_valid(ffok3), .seq_err(seq3));

  int n_tests = 0;
  int n_fail  = 0;
  int d0, d1, d3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic record_done(input int k);
    if (done0 && d0 < 0) d0 = k;
    if (done1 && d1 < 0) d1 = k;
    if (done3 && d3 < 0) d3 = k;
  endtask

  // Pulse start, then present vectors 0..255; k is the cycle index after start.
  task automatic sweep(input bit gaps, input bit swap, input bit mid_start, input bit extra);
    int k;
    int i;
    start     = 1'b1;
    vec_valid = 1'b0;
    step();
    start = 1'b0;
    k     = 1;
    check("start_busy",    32'(busy1), 1);
    check("start_done_lo", 32'(done1), 0);
    check("start_chk_clr", 32'(chk1),  0);
    check("start_err_clr", 32'(err1),  0);
    check("start_ff_clr",  32'(ffok1), 0);
    check("start_seq_clr", 32'(seq1),  0);
    d0 = -1;
    d1 = -1;
    d3 = -1;
    i  = 0;
    while (i < 256) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        vec_valid = 1'b0;
        vec       = 8'($urandom);
      end else begin
        vec_valid = 1'b1;
        if (swap && i == 5)      vec = 8'd6;
        else if (swap && i == 6) vec = 8'd5;
        else                     vec = 8'(i);
        i++;
      end
      start = mid_start && (k == 100);
      step();
      k++;
      record_done(k);
    end
    start     = 1'b0;
    vec_valid = extra;
    vec       = 8'h5A;
    while (!(done0 && done1 && done3) && k < 2000) begin
      step();
      k++;
      record_done(k);
    end
    check("sweep_done_all", 32'(done0 && done1 && done3), 1);
    if (extra) begin
      repeat (6) step();
    end
    vec_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    vec_valid = 1'b0;
    vec       = '0;
    stuck0    = 1'b0;
    repeat (3) step();
    check("rst_busy",   32'(busy1), 0);
    check("rst_done",   32'(done1), 0);
    check("rst_pass",   32'(pass1), 0);
    check("rst_chk",    32'(chk1),  0);
    check("rst_err",    32'(err1),  0);
    check("rst_ffv",    32'(ffv1),  0);
    check("rst_ffok",   32'(ffok1), 0);
    check("rst_seq",    32'(seq1),  0);
    check("rst_busy_l3", 32'(busy3), 0);
    rst = 1'b0;
    step();

    // Ideal OR, back-to-back, with a start pulse mid-RUN that must be ignored.
    sweep(1'b0, 1'b0, 1'b1, 1'b0);
    check("ideal_done_cyc_l1", 32'(d1), 258);
    check("ideal_done_cyc_l0", 32'(d0), 257);
    check("ideal_done_cyc_l3", 32'(d3), 260);
    check("ideal_chk",   32'(chk1),  256);
    check("ideal_err",   32'(err1),  0);
    check("ideal_pass",  32'(pass1), 1);
    check("ideal_seq",   32'(seq1),  0);
    check("ideal_busy",  32'(busy1), 0);
    check("ideal_ffok",  32'(ffok1), 0);
    check("ideal_pass_l0", 32'(pass0), 1);
    check("ideal_pass_l3", 32'(pass3), 1);

    // Stuck-at-0 DUT output; sweep starts from DONE.
    stuck0 = 1'b1;
    sweep(1'b0, 1'b0, 1'b0, 1'b0);
    stuck0 = 1'b0;
    check("stuck_chk",    32'(chk1),  256);
    check("stuck_err",    32'(err1),  255);
    check("stuck_ffv",    32'(ffv1),  1);
    check("stuck_ffok",   32'(ffok1), 1);
    check("stuck_pass",   32'(pass1), 0);
    check("stuck_err_l0", 32'(err0),  255);
    check("stuck_ffv_l0", 32'(ffv0),  1);
    check("stuck_err_l3", 32'(err3),  255);
    check("stuck_ffv_l3", 32'(ffv3),  1);
    repeat (4) step();
    check("stuck_hold_err",  32'(err1),  255);
    check("stuck_hold_done", 32'(done1), 1);

    // Vectors 5 and 6 swapped: order error only.
    sweep(1'b0, 1'b1, 1'b0, 1'b0);
    check("swap_seq",    32'(seq1),  1);
    check("swap_err",    32'(err1),  0);
    check("swap_pass",   32'(pass1), 0);
    check("swap_chk",    32'(chk1),  256);
    check("swap_seq_l3", 32'(seq3),  1);
    check("swap_seq_l0", 32'(seq0),  1);

    // Random vec_valid gaps, then extra vec_valid pulses after the sweep.
    sweep(1'b1, 1'b0, 1'b0, 1'b1);
    check("gap_chk_l0",  32'(chk0),  256);
    check("gap_chk_l1",  32'(chk1),  256);
    check("gap_chk_l3",  32'(chk3),  256);
    check("gap_pass_l0", 32'(pass0), 1);
    check("gap_pass_l1", 32'(pass1), 1);
    check("gap_pass_l3", 32'(pass3), 1);

    // Reset mid-sweep at chk_cnt=100, then a clean sweep.
    begin
      int i;
      int k;
      start = 1'b1;
      step();
      start = 1'b0;
      i     = 0;
      k     = 0;
      while (chk1 != 9'd100 && k < 1000) begin
        vec_valid = 1'b1;
        vec       = 8'(i);
        i++;
        step();
        k++;
      end
      check("mid_reach_100", 32'(chk1), 100);
      rst       = 1'b1;
      vec_valid = 1'b0;
      step();
      check("mid_rst_busy", 32'(busy1), 0);
      check("mid_rst_done", 32'(done1), 0);
      check("mid_rst_pass", 32'(pass1), 0);
      check("mid_rst_chk",  32'(chk1),  0);
      check("mid_rst_err",  32'(err1),  0);
      check("mid_rst_ffv",  32'(ffv1),  0);
      check("mid_rst_ffok", 32'(ffok1), 0);
      check("mid_rst_seq",  32'(seq1),  0);
      check("mid_rst_chk_l3", 32'(chk3), 0);
      rst = 1'b0;
      step();
      check("mid_idle_busy", 32'(busy1), 0);
    end

    sweep(1'b0, 1'b0, 1'b0, 1'b0);
    check("clean_done_cyc", 32'(d1),   258);
    check("clean_chk",      32'(chk1), 256);
    check("clean_pass",     32'(pass1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/or8_response_checker.md
# or8_response_checker

Hardware response checker for the 8-input OR gate. It receives each applied input vector and the DUT's output, compares the output against the golden OR reduction, and tallies results over an exhaustive 256-vector sweep (0 to 255, ascending). It is the receiving end of the exhaustive-stimulus flow, so gate-level self-test needs no simulator waveform inspection.

## Interface
- `WIDTH`, default 8: vector width. The sweep covers 2^WIDTH vectors.
- `LAT`, default 1: cycles between a vector being presented and its DUT result being valid on `dut_out`. Legal range 0 to 7.
- `clk` in, 1 bit: single clock. All logic is on the rising edge.
- `rst` in, 1 bit: reset, synchronous and active-high.
- `start` in, 1 bit: one-cycle pulse that begins a sweep.
- `vec_valid` in, 1 bit: `vec` holds an applied vector this cycle.
- `vec` in, WIDTH bits: vector applied to the DUT.
- `dut_out` in, 1 bit: DUT response to the vector presented LAT cycles earlier.
- `busy` out, 1 bit: FSM is in RUN.
- `done` out, 1 bit: FSM is in DONE.
- `pass` out, 1 bit: valid when `done` is high. Equals `err_cnt==0 && !seq_err`.
- `chk_cnt` out, WIDTH+1 bits: number of responses compared.
- `err_cnt` out, WIDTH+1 bits: number of mismatching responses.
- `first_fail_vec` out, WIDTH bits: the first vector whose response mismatched.
- `first_fail_valid` out, 1 bit: `first_fail_vec` holds a captured value.
- `seq_err` out, 1 bit: sticky flag. An accepted vector differed from the expected sweep index.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when `chk_cnt` reaches 2^WIDTH.
  - DONE → RUN on `start`.
- On any start into RUN, clear all counters, `seq_err`, `first_fail_*`, the expected-index counter and the delay line.
- Acceptance:
  - A vector is accepted when the FSM is in RUN, `vec_valid`=1, and the accepted count is below 2^WIDTH.
  - `vec_valid` is ignored in IDLE and DONE, and after 2^WIDTH vectors have been accepted.
- Sequence check:
  - An accepted `vec` is compared against the expected index, which starts at 0 and increments by 1 per accepted vector.
  - On mismatch, set `seq_err`. Checking continues regardless.
- Delay line: (`vec`, accept) pairs pass through a LAT-deep pipeline.
  - When the delayed accept emerges, compute expected = OR-reduction of the delayed vector and compare it with `dut_out`.
  - Each comparison increments `chk_cnt`.
  - Each mismatch increments `err_cnt`. If `first_fail_valid`=0, also capture the delayed vector and set `first_fail_valid`.
- LAT=0: compare `dut_out` against `vec` in the same cycle it is accepted.
- `start` while in RUN is ignored; it does not restart the sweep.
- Counter width WIDTH+1 holds 2^WIDTH exactly. No saturation is needed because at most 2^WIDTH vectors are accepted.

## Timing
- Reset: FSM goes to IDLE. Every output is 0 (`busy`, `done`, `pass`, `chk_cnt`, `err_cnt`, `first_fail_vec`, `first_fail_valid`, `seq_err`), and the delay line is cleared.
- `rst` has priority over `start` and over all updates. Reset mid-sweep discards the sweep completely.
- `start` sampled high in cycle t gives `busy`=1 in t+1. Counters read 0 in t+1.
- A vector accepted in cycle t is compared in cycle t+LAT. `chk_cnt` and `err_cnt` reflect it in t+LAT+1.
- The final comparison in cycle t gives `chk_cnt`=2^WIDTH, `done`=1, `busy`=0 and valid `pass`, all in t+1.
- Minimum sweep length, with back-to-back `vec_valid`: 2^WIDTH + LAT + 1 cycles from `start` to `done`.
- `vec_valid` may have gaps. Gaps only stretch the sweep.
- Outputs in DONE hold until the next `start` or `rst`.

## Structure
- Package `or_chk_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - constant `N_VEC` = 2^WIDTH for the default width;
  - the default LAT constant.
- Sub-module `chk_delay_line` is a LAT-deep shift register for {valid, vec}.
  - Synchronous clear input driven by `rst` or start-of-sweep.
  - LAT=0 is a pass-through.
- The top level contains the FSM, the expected-index counter, the comparator, the counters and the first-fail capture.

## Test plan
- Ideal OR model, LAT=1, vectors 0 to 255 back-to-back → `done` at cycle 258 after `start`, `chk_cnt`=256, `err_cnt`=0, `pass`=1, `seq_err`=0.
- DUT model stuck-at-0 output → `err_cnt`=255, `first_fail_vec`=0x01, `first_fail_valid`=1, `pass`=0.
- Ideal model, but vectors 5 and 6 swapped in order → `seq_err`=1, `err_cnt`=0, `pass`=0.
- LAT=0 and LAT=3 builds, with random `vec_valid` gaps → `chk_cnt`=256, `pass`=1. Extra `vec_valid` pulses after the 256th vector do not change `chk_cnt`.
- `rst` asserted at `chk_cnt`=100 → all outputs read 0 the next cycle. A new `start` then runs a clean sweep to `pass`=1.
- `start` pulsed mid-RUN → ignored, so totals are unchanged. `start` in DONE → counters cleared and `busy`=1 the next cycle.
